// File: rtl/dm_store_buffer_ram_pkg.sv
// Shared constants for the data-memory responder: default geometry and the
// byte-enable patterns produced by the M stage for sw/sh/sb.
package dm_store_buffer_ram_pkg;

  localparam int          DM_ADDR_W  = 12;
  localparam logic [31:0] DM_BASE    = 32'h0000_0000;

  localparam logic [3:0]  BE_NONE    = 4'b0000;
  localparam logic [3:0]  BE_WORD    = 4'b1111;
  localparam logic [3:0]  BE_HALF_LO = 4'b0011;
  localparam logic [3:0]  BE_HALF_HI = 4'b1100;
  localparam logic [3:0]  BE_B0      = 4'b0001;
  localparam logic [3:0]  BE_B1      = 4'b0010;
  localparam logic [3:0]  BE_B2      = 4'b0100;
  localparam logic [3:0]  BE_B3      = 4'b1000;

endpackage

// File: rtl/dm_store_buffer_ram_if.sv
// M-stage data port. There is no valid/ready handshake: a nonzero byteen is a
// write that is taken unconditionally at the next rising edge, and rdata is a
// zero-latency combinational read of the current address. The log_* signals
// describe the write that the coming edge will accept.
interface dm_store_buffer_ram_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        log_valid;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    input  m_data_rdata, log_valid, log_pc, log_addr, log_data
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
    output m_data_rdata, log_valid, log_pc, log_addr, log_data
  );
endinterface

// File: rtl/dm_lane_merge.sv
// Per-byte mux: lanes with mask set come from new_word, the rest from old_word.
module dm_lane_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  mask,
  output logic [31:0] merged
);
  always_comb begin
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
  end
endmodule

// File: rtl/dm_store_buffer_ram.sv
// Word-addressed data memory with a one-entry store buffer; loads forward
// pending buffer bytes so a load right after a store sees the new data.
module dm_store_buffer_ram
  import dm_store_buffer_ram_pkg::*;
#(
  parameter int          ADDR_W = DM_ADDR_W,
  parameter logic [31:0] BASE   = DM_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  dm_store_buffer_ram_if.slave  bus,
  output logic [31:0]           wr_count,
  output logic                  err_oor,
  output logic                  dbg_sb_v
);
  localparam int          DEPTH = 2 ** ADDR_W;
  localparam logic [63:0] SPAN  = 64'd4 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              sb_v;
  logic [ADDR_W-1:0] sb_idx;
  logic [31:0]       sb_data;
  logic [3:0]        sb_be;

  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              hit;
  logic              wr_acc;
  logic              wr_oor;
  logic [31:0]       fwd_word;
  logic [31:0]       new_word;
  logic [31:0]       commit_word;

  assign off      = bus.m_data_addr - BASE;
  assign in_range = {32'd0, off} < SPAN;
  assign idx      = off[ADDR_W+1:2];
  assign hit      = sb_v && (sb_idx == idx);
  assign wr_acc   = (bus.m_data_byteen != BE_NONE) && in_range;
  assign wr_oor   = (bus.m_data_byteen != BE_NONE) && !in_range;

  // Current view of the addressed word: array overlaid with pending buffer lanes.
  dm_lane_merge u_fwd (
    .old_word (mem[idx]),
    .new_word (sb_data),
    .mask     (hit ? sb_be : BE_NONE),
    .merged   (fwd_word)
  );

  // Word as it will read after this store; also the merged buffer contents.
  dm_lane_merge u_new (
    .old_word (fwd_word),
    .new_word (bus.m_data_wdata),
    .mask     (bus.m_data_byteen),
    .merged   (new_word)
  );

  dm_lane_merge u_commit (
    .old_word (mem[sb_idx]),
    .new_word (sb_data),
    .mask     (sb_be),
    .merged   (commit_word)
  );

  assign bus.m_data_rdata = in_range ? fwd_word : 32'd0;
  assign bus.log_valid    = wr_acc;
  assign bus.log_pc       = bus.m_inst_addr;
  assign bus.log_addr     = {bus.m_data_addr[31:2], 2'b00};
  assign bus.log_data     = new_word;
  assign dbg_sb_v         = sb_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
      sb_v     <= 1'b0;
      sb_idx   <= '0;
      sb_data  <= 32'd0;
      sb_be    <= BE_NONE;
      wr_count <= 32'd0;
      err_oor  <= 1'b0;
    end else begin
      if (wr_oor) err_oor <= 1'b1;
      if (wr_acc) begin
        wr_count <= wr_count + 32'd1;
        if (hit) begin
          // Same-word store: keep merging, nothing reaches the array yet.
          sb_data <= new_word;
          sb_be   <= sb_be | bus.m_data_byteen;
        end else begin
          if (sb_v) mem[sb_idx] <= commit_word;
          sb_idx  <= idx;
          sb_data <= bus.m_data_wdata;
          sb_be   <= bus.m_data_byteen;
          sb_v    <= 1'b1;
        end
      end else begin
        if (sb_v) mem[sb_idx] <= commit_word;
        sb_v  <= 1'b0;
        sb_be <= BE_NONE;
      end
    end
  end
endmodule

// File: tb/tb_dm_store_buffer_ram.sv
// Directed bench for dm_store_buffer_ram: a vector table run from reset, then
// a hand-written mid-operation reset sequence.
module tb_dm_store_buffer_ram;
  import dm_store_buffer_ram_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] wr_count;
  logic        err_oor;
  logic        dbg_sb_v;

  int checks = 0;
  int errors = 0;

  dm_store_buffer_ram_if bus ();

  dm_store_buffer_ram dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .wr_count (wr_count),
    .err_oor  (err_oor),
    .dbg_sb_v (dbg_sb_v)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store log, printed for every write the coming edge accepts.
  always @(posedge clk) begin
    if (reset && bus.log_valid)
      $display("%d@%h: *%h <= %h", $time, bus.log_pc, bus.log_addr, bus.log_data);
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] pc);
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = wdata;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;   // combinational read before the edge
    logic        exp_log;
    logic [31:0] exp_log_data;
    logic [31:0] exp_wr_count; // after the edge
    logic        exp_sb_v;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] rd, input logic lg, input logic [31:0] ld,
                     input logic [31:0] wc, input logic sv, input logic er);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = rd; v.exp_log = lg; v.exp_log_data = ld;
    v.exp_wr_count = wc; v.exp_sb_v = sv; v.exp_err = er;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    drive(32'h10, 32'd0, BE_NONE, 32'h0);

    //   addr          wdata         be          rdata         log   log data      wr  sb_v err
    add(32'h0000_0010, 32'h0,        BE_NONE,    32'h0,        1'b0, 32'h0,        0,  1'b0, 1'b0);
    add(32'h0000_0020, 32'h11223344, BE_WORD,    32'h0,        1'b1, 32'h11223344, 1,  1'b1, 1'b0);
    add(32'h0000_0020, 32'h0,        BE_NONE,    32'h11223344, 1'b0, 32'h0,        1,  1'b0, 1'b0);
    add(32'h0000_0020, 32'h0,        BE_NONE,    32'h11223344, 1'b0, 32'h0,        1,  1'b0, 1'b0);
    add(32'h0000_0040, 32'hAABBCCDD, BE_WORD,    32'h0,        1'b1, 32'hAABBCCDD, 2,  1'b1, 1'b0);
    add(32'h0000_0041, 32'hEEEEEEEE, BE_B1,      32'hAABBCCDD, 1'b1, 32'hAABBEEDD, 3,  1'b1, 1'b0);
    add(32'h0000_0040, 32'h0,        BE_NONE,    32'hAABBEEDD, 1'b0, 32'h0,        3,  1'b0, 1'b0);
    add(32'h0000_0040, 32'h01020304, BE_WORD,    32'hAABBEEDD, 1'b1, 32'h01020304, 4,  1'b1, 1'b0);
    add(32'h0000_0044, 32'h00000055, BE_WORD,    32'h0,        1'b1, 32'h00000055, 5,  1'b1, 1'b0);
    add(32'h0000_0040, 32'h0,        BE_NONE,    32'h01020304, 1'b0, 32'h0,        5,  1'b0, 1'b0);
    add(32'h0000_0044, 32'h0,        BE_NONE,    32'h00000055, 1'b0, 32'h0,        5,  1'b0, 1'b0);
    add(32'h0000_0043, 32'h0,        BE_NONE,    32'h01020304, 1'b0, 32'h0,        5,  1'b0, 1'b0);
    add(32'h0000_0044, 32'h99887766, 4'b0110,    32'h00000055, 1'b1, 32'h00887755, 6,  1'b1, 1'b0);
    add(32'h0000_0046, 32'hBEEFBEEF, BE_HALF_HI, 32'h00887755, 1'b1, 32'hBEEF7755, 7,  1'b1, 1'b0);
    add(32'h0000_0044, 32'h0,        BE_NONE,    32'hBEEF7755, 1'b0, 32'h0,        7,  1'b0, 1'b0);
    add(32'h0000_3FFC, 32'hCAFEF00D, BE_WORD,    32'h0,        1'b1, 32'hCAFEF00D, 8,  1'b1, 1'b0);
    add(32'h0000_3FFC, 32'h0,        BE_NONE,    32'hCAFEF00D, 1'b0, 32'h0,        8,  1'b0, 1'b0);
    add(32'h0000_4000, 32'h0,        BE_NONE,    32'h0,        1'b0, 32'h0,        8,  1'b0, 1'b0);
    add(32'h0000_4000, 32'hFFFFFFFF, BE_WORD,    32'h0,        1'b0, 32'h0,        8,  1'b0, 1'b1);
    add(32'h0000_4000, 32'h0,        BE_NONE,    32'h0,        1'b0, 32'h0,        8,  1'b0, 1'b1);
    add(32'h0000_0000, 32'h0,        BE_NONE,    32'h0,        1'b0, 32'h0,        8,  1'b0, 1'b1);
    add(32'hFFFF_FFFC, 32'h0,        BE_NONE,    32'h0,        1'b0, 32'h0,        8,  1'b0, 1'b1);
    add(32'h0000_0040, 32'h0,        BE_NONE,    32'h01020304, 1'b0, 32'h0,        8,  1'b0, 1'b1);

    // Reset is released at a falling edge, away from the active edge.
    repeat (2) @(negedge clk);
    #1;
    chk("rdata_in_reset", bus.m_data_rdata, 32'h0);
    reset = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].be, 32'h0000_1000 + 32'(4 * i));
      #1;
      chk($sformatf("v%0d_rdata", i), bus.m_data_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_log_valid", i), {31'd0, bus.log_valid}, {31'd0, vecs[i].exp_log});
      if (vecs[i].exp_log)
        chk($sformatf("v%0d_log_data", i), bus.log_data, vecs[i].exp_log_data);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_count", i), wr_count, vecs[i].exp_wr_count);
      chk($sformatf("v%0d_sb_v", i), {31'd0, dbg_sb_v}, {31'd0, vecs[i].exp_sb_v});
      chk($sformatf("v%0d_err_oor", i), {31'd0, err_oor}, {31'd0, vecs[i].exp_err});
    end

    // ---------------- reset with a store still pending ----------------
    @(negedge clk);
    drive(32'h0000_0080, 32'h12345678, BE_WORD, 32'h0000_2000);
    @(posedge clk);
    #1;
    chk("pend_sb_v", {31'd0, dbg_sb_v}, 32'd1);
    chk("pend_fwd", bus.m_data_rdata, 32'h12345678);
    drive(32'h0000_0080, 32'h0, BE_NONE, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_rdata_low", bus.m_data_rdata, 32'h0);
    chk("rst_wr_count_low", wr_count, 32'h0);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rdata_80", bus.m_data_rdata, 32'h0);
    chk("rst_wr_count", wr_count, 32'h0);
    chk("rst_err_oor", {31'd0, err_oor}, 32'd0);
    chk("rst_sb_v", {31'd0, dbg_sb_v}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_rdata_80_after_edge", bus.m_data_rdata, 32'h0);
    drive(32'h0000_0020, 32'h0, BE_NONE, 32'h0);
    #1;
    chk("rst_rdata_20", bus.m_data_rdata, 32'h0);
    drive(32'h0000_0040, 32'h0, BE_NONE, 32'h0);
    #1;
    chk("rst_rdata_40", bus.m_data_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_store_buffer_ram.md
Name: dm_store_buffer_ram

Overview:
- Data-memory responder on the M-stage data port: consumes m_data_addr / m_data_wdata / m_data_byteen and returns m_data_rdata.
- Writes land in a one-entry store buffer and commit to the word array one edge later.
- Reads see a byte-lane merge of the array and any pending buffer entry, so a load immediately after a store returns the stored bytes.
- Sits outside the CPU core, in the testbench/top level, in place of a plain DM array.

Parameters:
ADDR_W, 12, word-index width; depth = 2**ADDR_W words (4096 words = 16 KiB)
BASE, 32'h0000_0000, byte base address of the array

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
m_data_addr  input  32  byte address from M stage
m_data_wdata  input  32  write data, already lane-replicated by M stage
m_data_byteen  input  4  byte write enables; 4'b0000 = no write
m_inst_addr  input  32  PC of the M-stage instruction, used only for write logging
m_data_rdata  output  32  read word (combinational)
wr_count  output  32  number of accepted writes, wraps at 2**32
err_oor  output  1  sticky out-of-range flag

Behaviour:
- Address decode: off = addr - BASE. In range iff off < 4*2**ADDR_W. idx = off[ADDR_W+1:2]. addr[1:0] is ignored; lanes come from byteen.
- State: mem[0:2**ADDR_W-1] (32-bit words); buffer {sb_v, sb_idx, sb_data[31:0], sb_be[3:0]}.
- Reset (reset==0, asynchronous): sb_v=0, sb_be=0, sb_data=0, wr_count=0, err_oor=0, all mem words 0. m_data_rdata therefore reads 0 during and after reset.
- Read, combinational, zero latency:
  - Out of range: m_data_rdata = 0.
  - Otherwise, for each lane k: byte k = sb_data byte k if sb_v && sb_idx==idx && sb_be[k]; else mem[idx] byte k.
- Write acceptance, at posedge: a write is accepted iff byteen != 0 and the address is in range.
- Each posedge, first matching rule applies:
  - (a) Accepted write with sb_v && sb_idx==idx (merge): lanes with byteen[k] take wdata byte k; sb_be |= byteen; sb_v stays 1; no commit to mem.
  - (b) Accepted write otherwise: if sb_v, commit the buffer to mem[sb_idx] on lanes sb_be only. Then load the buffer with sb_idx=idx, sb_data=wdata, sb_be=byteen, sb_v=1.
  - (c) No accepted write: if sb_v, commit the buffer; sb_v=0, sb_be=0.
- Maximum residency in the buffer: one cycle after the last write to that word. Consecutive same-word stores keep merging.
- Accepted write: wr_count += 1 and emit $display("%d@%h: *%h <= %h", $time, m_inst_addr, {addr[31:2],2'b00}, merged word). The logged data is the full word as it will read after this store (mem/buffer merge), not raw wdata.
- Out-of-range write (byteen != 0): ignored, no log, err_oor=1 until reset. Out-of-range read with byteen==0 does not set err_oor.
- Reset mid-operation: the pending buffer is discarded, not committed.
- byteen values outside the aligned patterns (e.g. 4'b0110) are still honoured lane by lane; no error.

Decomposition:
- Shared package/include: DM_ADDR_W, DM_BASE, byteen constants BE_WORD=4'b1111, BE_HALF_LO=4'b0011, BE_HALF_HI=4'b1100, BE_B0..BE_B3.
- One natural sub-module, dm_lane_merge: combinational 4-lane byte mux, (old word, new word, mask) -> merged word. Used for read forwarding, buffer merge, commit and log data.

Test Plan:
- Reset then read addr 0x10 -> rdata 0, wr_count 0, err_oor 0.
- sw 0x11223344 @0x20 (be 1111); next cycle read 0x20 with no write -> 0x11223344 via buffer. After one idle edge, sb_v=0 and the read still returns 0x11223344 from mem.
- sw 0xAABBCCDD @0x40, then back-to-back sb 0x000000EE lane 1 @0x41 (be 0010, wdata 0xEEEEEEEE) -> read 0xAABBEEDD; wr_count +2; second log shows 0xaabbeedd.
- sw @0x40 then sw 0x55 @0x44 on consecutive edges -> first commits at the second edge; reads 0x40 and 0x44 both correct in every cycle.
- Write be 1111 to BASE+0x4000 (depth 4096) -> mem unchanged, no log, err_oor=1 and stays 1; read there -> 0.
- Pending store then reset pulse low between edges -> after release, read of that address = 0, wr_count 0, err_oor 0.
